eco32f_wb_arbiter: RTL and testbench

Two-master, one-slave Wishbone arbiter that shares the core's single external bus between the instruction fetch port (ibus) and the load/store port (dbus). It holds a grant for a master's whole bus cycle, so 8-beat wrapping refill bursts are never split. It alternates priority between the two masters. A bus watchdog terminates any stalled transfer with an error so fetch or load/store logic cannot hang.

---
 rtl/eco32f_wb_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_eco32f_wb_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eco32f_wb_arbiter.sv
// Two-master (fetch/load-store) to one-slave Wishbone arbiter with alternating
// priority, whole-cycle grant holding and a stalled-beat watchdog.
module eco32f_wb_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,

   input  logic [31:0] ibus_adr_i,
   input  logic [31:0] ibus_dat_i,
   input  logic        ibus_cyc_i,
   input  logic        ibus_stb_i,
   input  logic        ibus_we_i,
   input  logic [3:0]  ibus_sel_i,
   input  logic [2:0]  ibus_cti_i,
   input  logic [1:0]  ibus_bte_i,
   output logic [31:0] ibus_dat_o,
   output logic        ibus_ack_o,
   output logic        ibus_err_o,
   output logic        ibus_rty_o,

   input  logic [31:0] dbus_adr_i,
   input  logic [31:0] dbus_dat_i,
   input  logic        dbus_cyc_i,
   input  logic        dbus_stb_i,
   input  logic        dbus_we_i,
   input  logic [3:0]  dbus_sel_i,
   input  logic [2:0]  dbus_cti_i,
   input  logic [1:0]  dbus_bte_i,
   output logic [31:0] dbus_dat_o,
   output logic        dbus_ack_o,
   output logic        dbus_err_o,
   output logic        dbus_rty_o,

   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [2:0]  wbm_cti_o,
   output logic [1:0]  wbm_bte_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i,
   input  logic        wbm_rty_i,

   output logic [1:0]  grant_o
);

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = 4;
   localparam int unsigned CW  = 3;
   localparam int unsigned BW  = 2;
   localparam int unsigned WDW = 8;

   localparam bit           WDOG_EN   = (TIMEOUT != 0);
   localparam logic [WDW-1:0] WDOG_LAST = WDOG_EN ? WDW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_I = 2'd1,
      OWN_D = 2'd2
   } state_t;

   // Master-side request payload routed to the slave
   typedef struct packed {
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
      logic [SW-1:0] sel;
      logic          we;
      logic [CW-1:0] cti;
      logic [BW-1:0] bte;
      logic          cyc;
      logic          stb;
   } wb_req_t;

   state_t         state, state_nxt;
   logic           last_d, last_d_nxt;      // last owner: 0 = ibus, 1 = dbus
   logic [WDW-1:0] wdog_cnt, wdog_nxt;

   wb_req_t ibus_req_c, dbus_req_c, sel_req_c;
   logic    term_c, wdog_err_c;

   assign ibus_req_c = '{adr: ibus_adr_i, dat: ibus_dat_i, sel: ibus_sel_i,
                         we: ibus_we_i, cti: ibus_cti_i, bte: ibus_bte_i,
                         cyc: ibus_cyc_i, stb: ibus_stb_i};
   assign dbus_req_c = '{adr: dbus_adr_i, dat: dbus_dat_i, sel: dbus_sel_i,
                         we: dbus_we_i, cti: dbus_cti_i, bte: dbus_bte_i,
                         cyc: dbus_cyc_i, stb: dbus_stb_i};

   assign term_c = wbm_ack_i | wbm_err_i | wbm_rty_i;

   // State, priority and watchdog registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         last_d   <= 1'b0;
         wdog_cnt <= '0;
      end else begin
         state    <= state_nxt;
         last_d   <= last_d_nxt;
         wdog_cnt <= wdog_nxt;
      end
   end

   // Arbitration, bus mux, termination routing and watchdog
   always_comb begin
      state_nxt  = state;
      last_d_nxt = last_d;
      wdog_nxt   = '0;
      wdog_err_c = 1'b0;
      sel_req_c  = '0;
      ibus_ack_o = 1'b0;
      ibus_err_o = 1'b0;
      ibus_rty_o = 1'b0;
      dbus_ack_o = 1'b0;
      dbus_err_o = 1'b0;
      dbus_rty_o = 1'b0;

      case (state)
         IDLE: begin
            if (ibus_cyc_i && dbus_cyc_i) begin
               state_nxt = last_d ? OWN_I : OWN_D;
            end else if (ibus_cyc_i) begin
               state_nxt = OWN_I;
            end else if (dbus_cyc_i) begin
               state_nxt = OWN_D;
            end
         end
         OWN_I: begin
            sel_req_c = ibus_req_c;
            if (!ibus_cyc_i) begin
               state_nxt  = IDLE;
               last_d_nxt = 1'b0;
            end
         end
         OWN_D: begin
            sel_req_c = dbus_req_c;
            if (!dbus_cyc_i) begin
               state_nxt  = IDLE;
               last_d_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // stb is qualified by cyc, so the release cycle never counts as stalled
      sel_req_c.stb = sel_req_c.stb & sel_req_c.cyc;

      if (sel_req_c.stb && !term_c) begin
         if (WDOG_EN && (wdog_cnt == WDOG_LAST)) begin
            wdog_err_c = 1'b1;
         end else begin
            wdog_nxt = wdog_cnt + WDW'(1);
         end
      end

      if (state == OWN_I) begin
         ibus_ack_o = wbm_ack_i;
         ibus_err_o = wbm_err_i | wdog_err_c;
         ibus_rty_o = wbm_rty_i;
      end
      if (state == OWN_D) begin
         dbus_ack_o = wbm_ack_i;
         dbus_err_o = wbm_err_i | wdog_err_c;
         dbus_rty_o = wbm_rty_i;
      end
   end

   assign wbm_adr_o = sel_req_c.adr;
   assign wbm_dat_o = sel_req_c.dat;
   assign wbm_sel_o = sel_req_c.sel;
   assign wbm_we_o  = sel_req_c.we;
   assign wbm_cti_o = sel_req_c.cti;
   assign wbm_bte_o = sel_req_c.bte;
   assign wbm_cyc_o = sel_req_c.cyc;
   assign wbm_stb_o = sel_req_c.stb;

   assign ibus_dat_o = wbm_dat_i;
   assign dbus_dat_o = wbm_dat_i;

   assign grant_o = {state == OWN_D, state == OWN_I};

endmodule

// File: tb/tb_eco32f_wb_arbiter.sv
// Self-checking bench for eco32f_wb_arbiter: directed table, corner-case
// sequences and a randomized run against a behavioural model.
module tb_eco32f_wb_arbiter;

   localparam int TO = 4;
   localparam logic [31:0] IA = 32'hE0000010;
   localparam logic [31:0] DA = 32'h00001000;

   logic clk, rst;
   logic [31:0] ibus_adr_i, ibus_dat_i, dbus_adr_i, dbus_dat_i, wbm_dat_i;
   logic ibus_cyc_i, ibus_stb_i, ibus_we_i, dbus_cyc_i, dbus_stb_i, dbus_we_i;
   logic [3:0] ibus_sel_i, dbus_sel_i;
   logic [2:0] ibus_cti_i, dbus_cti_i;
   logic [1:0] ibus_bte_i, dbus_bte_i;
   logic wbm_ack_i, wbm_err_i, wbm_rty_i;
   logic [31:0] ibus_dat_o, dbus_dat_o, wbm_adr_o, wbm_dat_o;
   logic ibus_ack_o, ibus_err_o, ibus_rty_o, dbus_ack_o, dbus_err_o, dbus_rty_o;
   logic wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0] wbm_sel_o;
   logic [2:0] wbm_cti_o;
   logic [1:0] wbm_bte_o, grant_o;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: who owns the bus (0 none, 1 ibus, 2 dbus), who had it
   // last, and how many consecutive strobed cycles have gone unanswered.
   int m_owner, m_last, m_wait;

   eco32f_wb_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ibus_adr_i(ibus_adr_i), .ibus_dat_i(ibus_dat_i), .ibus_cyc_i(ibus_cyc_i),
      .ibus_stb_i(ibus_stb_i), .ibus_we_i(ibus_we_i), .ibus_sel_i(ibus_sel_i),
      .ibus_cti_i(ibus_cti_i), .ibus_bte_i(ibus_bte_i), .ibus_dat_o(ibus_dat_o),
      .ibus_ack_o(ibus_ack_o), .ibus_err_o(ibus_err_o), .ibus_rty_o(ibus_rty_o),
      .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i), .dbus_cyc_i(dbus_cyc_i),
      .dbus_stb_i(dbus_stb_i), .dbus_we_i(dbus_we_i), .dbus_sel_i(dbus_sel_i),
      .dbus_cti_i(dbus_cti_i), .dbus_bte_i(dbus_bte_i), .dbus_dat_o(dbus_dat_o),
      .dbus_ack_o(dbus_ack_o), .dbus_err_o(dbus_err_o), .dbus_rty_o(dbus_rty_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
      .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
      .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
      .grant_o(grant_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  in;   // {ic, is, dc, ds, ack, err, rty}
      logic [1:0]  gnt;
      logic [7:0]  out;  // {wcyc, wstb, iack, ierr, irty, dack, derr, drty}
      logic [31:0] adr;
   } vec_t;

   vec_t tbl [25];

   function automatic vec_t mk(logic [6:0] in, logic [1:0] g, logic [7:0] o, logic [31:0] a);
      vec_t v;
      v.in = in; v.gnt = g; v.out = o; v.adr = a;
      return v;
   endfunction

   task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ibus_adr_i = '0; ibus_dat_i = '0; ibus_cyc_i = 0; ibus_stb_i = 0; ibus_we_i = 0;
      ibus_sel_i = '0; ibus_cti_i = '0; ibus_bte_i = '0;
      dbus_adr_i = '0; dbus_dat_i = '0; dbus_cyc_i = 0; dbus_stb_i = 0; dbus_we_i = 0;
      dbus_sel_i = '0; dbus_cti_i = '0; dbus_bte_i = '0;
      wbm_dat_i = '0; wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      m_owner = 0; m_last = 1; m_wait = 0;
      step();
      rst = 1'b1;
   endtask

   function automatic logic [159:0] dut_vec();
      return {12'b0, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
              wbm_cti_o, wbm_bte_o, ibus_dat_o, ibus_ack_o, ibus_err_o, ibus_rty_o,
              dbus_dat_o, dbus_ack_o, dbus_err_o, dbus_rty_o, grant_o};
   endfunction

   function automatic logic stalled_out();
      logic stb, term;
      stb  = (m_owner == 1) ? (ibus_cyc_i & ibus_stb_i) :
             (m_owner == 2) ? (dbus_cyc_i & dbus_stb_i) : 1'b0;
      term = wbm_ack_i | wbm_err_i | wbm_rty_i;
      return stb && !term && (m_wait + 1 == TO);
   endfunction

   function automatic logic [159:0] model_vec();
      logic [31:0] adr, dat; logic [3:0] sel; logic we, cyc, stb;
      logic [2:0] cti; logic [1:0] bte, g;
      logic ia, ie, ir, da, de, dr, forced;
      adr = '0; dat = '0; sel = '0; we = 0; cyc = 0; stb = 0; cti = '0; bte = '0;
      ia = 0; ie = 0; ir = 0; da = 0; de = 0; dr = 0; g = 2'b00;
      forced = stalled_out();
      if (m_owner == 1) begin
         adr = ibus_adr_i; dat = ibus_dat_i; sel = ibus_sel_i; we = ibus_we_i;
         cti = ibus_cti_i; bte = ibus_bte_i; cyc = ibus_cyc_i; stb = ibus_cyc_i & ibus_stb_i;
         ia = wbm_ack_i; ie = wbm_err_i | forced; ir = wbm_rty_i; g = 2'b01;
      end else if (m_owner == 2) begin
         adr = dbus_adr_i; dat = dbus_dat_i; sel = dbus_sel_i; we = dbus_we_i;
         cti = dbus_cti_i; bte = dbus_bte_i; cyc = dbus_cyc_i; stb = dbus_cyc_i & dbus_stb_i;
         da = wbm_ack_i; de = wbm_err_i | forced; dr = wbm_rty_i; g = 2'b10;
      end
      return {12'b0, adr, dat, sel, we, cyc, stb, cti, bte, wbm_dat_i, ia, ie, ir,
              wbm_dat_i, da, de, dr, g};
   endfunction

   task automatic model_step();
      logic cyc, stb, term, forced;
      term   = wbm_ack_i | wbm_err_i | wbm_rty_i;
      forced = stalled_out();
      if (m_owner == 0) begin
         if (ibus_cyc_i && dbus_cyc_i) m_owner = (m_last == 1) ? 2 : 1;
         else if (ibus_cyc_i)          m_owner = 1;
         else if (dbus_cyc_i)          m_owner = 2;
         m_wait = 0;
      end else begin
         cyc = (m_owner == 1) ? ibus_cyc_i : dbus_cyc_i;
         stb = cyc & ((m_owner == 1) ? ibus_stb_i : dbus_stb_i);
         if (!cyc) begin
            m_last = m_owner; m_owner = 0; m_wait = 0;
         end else if (stb && !term && !forced) begin
            m_wait++;
         end else begin
            m_wait = 0;
         end
      end
   endtask

   logic [31:0] exp_adr;
   int acks, got, seen;
   logic dack_seen, i_done, d_done;
   logic [1:0] prev_g;
   logic [1:0] gseq [6];

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0;
      clear_inputs();
      wbm_dat_i = 32'hA5A50001;
      ibus_cyc_i = 1; ibus_stb_i = 1; ibus_adr_i = IA;
      m_owner = 0; m_last = 1; m_wait = 0;
      #12;
      chk("reset_state", dut_vec(), model_vec());
      step();

      // Directed table from reset
      tbl[0]  = mk(7'b1111100, 2'b00, 8'b00000000, 32'h0);
      tbl[1]  = mk(7'b1111000, 2'b10, 8'b11000000, DA);
      tbl[2]  = mk(7'b1111100, 2'b10, 8'b11000100, DA);
      tbl[3]  = mk(7'b1100000, 2'b10, 8'b00000000, DA);
      tbl[4]  = mk(7'b1100000, 2'b00, 8'b00000000, 32'h0);
      tbl[5]  = mk(7'b1100000, 2'b01, 8'b11000000, IA);
      tbl[6]  = mk(7'b1100000, 2'b01, 8'b11000000, IA);
      tbl[7]  = mk(7'b1100000, 2'b01, 8'b11000000, IA);
      tbl[8]  = mk(7'b1100000, 2'b01, 8'b11010000, IA);
      tbl[9]  = mk(7'b1100000, 2'b01, 8'b11000000, IA);
      tbl[10] = mk(7'b1100000, 2'b01, 8'b11000000, IA);
      tbl[11] = mk(7'b1100000, 2'b01, 8'b11000000, IA);
      tbl[12] = mk(7'b1100100, 2'b01, 8'b11100000, IA);
      tbl[13] = mk(7'b0011000, 2'b01, 8'b00000000, IA);
      tbl[14] = mk(7'b0011000, 2'b00, 8'b00000000, 32'h0);
      tbl[15] = mk(7'b0010000, 2'b10, 8'b10000000, DA);
      tbl[16] = mk(7'b0011010, 2'b10, 8'b11000010, DA);
      tbl[17] = mk(7'b0000000, 2'b10, 8'b00000000, DA);
      tbl[18] = mk(7'b1111000, 2'b00, 8'b00000000, 32'h0);
      tbl[19] = mk(7'b1111100, 2'b01, 8'b11100000, IA);
      tbl[20] = mk(7'b0011000, 2'b01, 8'b00000000, IA);
      tbl[21] = mk(7'b0011000, 2'b00, 8'b00000000, 32'h0);
      tbl[22] = mk(7'b0011001, 2'b10, 8'b11000001, DA);
      tbl[23] = mk(7'b0000000, 2'b10, 8'b00000000, DA);
      tbl[24] = mk(7'b0000000, 2'b00, 8'b00000000, 32'h0);

      do_reset();
      ibus_adr_i = IA; dbus_adr_i = DA;
      for (int r = 0; r < 25; r++) begin
         {ibus_cyc_i, ibus_stb_i, dbus_cyc_i, dbus_stb_i, wbm_ack_i, wbm_err_i, wbm_rty_i} = tbl[r].in;
         #4;
         chk($sformatf("table_row%0d", r),
             160'({grant_o, wbm_cyc_o, wbm_stb_o, ibus_ack_o, ibus_err_o, ibus_rty_o,
                   dbus_ack_o, dbus_err_o, dbus_rty_o, wbm_adr_o}),
             160'({tbl[r].gnt, tbl[r].out, tbl[r].adr}));
         step();
      end

      // Single 8-beat wrapping fetch burst
      do_reset();
      ibus_cyc_i = 1; ibus_stb_i = 1; ibus_cti_i = 3'b010; ibus_bte_i = 2'b10; ibus_adr_i = IA;
      wbm_ack_i = 1;
      #4 chk("burst_idle", 160'(grant_o), 160'(2'b00));
      step();
      acks = 0; dack_seen = 0;
      for (int b = 0; b < 8; b++) begin
         exp_adr = 32'hE0000000 | ((32'h10 + 32'(4 * b)) & 32'h1F);
         ibus_adr_i = exp_adr;
         ibus_cti_i = (b == 7) ? 3'b111 : 3'b010;
         #4;
         if (b == 0) chk("burst_grant", 160'(grant_o), 160'(2'b01));
         chk($sformatf("burst_adr%0d", b), 160'({wbm_adr_o, wbm_cti_o}), 160'({exp_adr, ibus_cti_i}));
         if (ibus_ack_o) acks++;
         if (dbus_ack_o) dack_seen = 1;
         step();
      end
      ibus_cyc_i = 0; ibus_stb_i = 0; wbm_ack_i = 0;
      #4 chk("burst_release", 160'({grant_o, wbm_cyc_o, wbm_stb_o}), 160'({2'b01, 2'b00}));
      step();
      #4 chk("burst_idle_after", 160'(grant_o), 160'(2'b00));
      chk("burst_ack_count", 160'(acks), 160'(8));
      chk("burst_no_dack", 160'(dack_seen), 160'(0));
      step();

      // Simultaneous request right after reset, then the other master
      do_reset();
      ibus_cyc_i = 1; ibus_stb_i = 1; dbus_cyc_i = 1; dbus_stb_i = 1; wbm_ack_i = 1;
      step();
      #4 chk("simul_first_d", 160'(grant_o), 160'(2'b10));
      step();
      dbus_cyc_i = 0; dbus_stb_i = 0;
      step();
      #4 chk("simul_gap_idle", 160'(grant_o), 160'(2'b00));
      step();
      #4 chk("simul_then_i", 160'(grant_o), 160'(2'b01));
      step();

      // Round robin under continuous contention
      do_reset();
      wbm_ack_i = 1;
      i_done = 0; d_done = 0; got = 0; prev_g = 2'b00;
      for (int c = 0; c < 60 && got < 6; c++) begin
         ibus_cyc_i = !i_done; ibus_stb_i = !i_done;
         dbus_cyc_i = !d_done; dbus_stb_i = !d_done;
         #4;
         if (prev_g == 2'b00 && grant_o != 2'b00) begin
            gseq[got] = grant_o;
            got++;
         end
         prev_g = grant_o;
         i_done = ibus_ack_o && ibus_cyc_i;
         d_done = dbus_ack_o && dbus_cyc_i;
         step();
      end
      chk("rr_count", 160'(got), 160'(6));
      for (int k = 0; k < got; k++)
         chk($sformatf("rr_grant%0d", k), 160'(gseq[k]), 160'((k % 2 == 0) ? 2'b10 : 2'b01));

      // Burst not split by a dbus request arriving mid-burst
      do_reset();
      ibus_cyc_i = 1; ibus_stb_i = 1; ibus_cti_i = 3'b010; ibus_bte_i = 2'b10; ibus_adr_i = IA;
      dbus_adr_i = DA; wbm_ack_i = 1;
      step();
      seen = 0;
      for (int b = 0; b < 8; b++) begin
         ibus_adr_i = 32'hE0000000 | ((32'h10 + 32'(4 * b)) & 32'h1F);
         if (b == 3) begin dbus_cyc_i = 1; dbus_stb_i = 1; end
         #4;
         if (wbm_adr_o !== ibus_adr_i || dbus_ack_o !== 1'b0) seen++;
         step();
      end
      chk("nosplit_hold", 160'(seen), 160'(0));
      ibus_cyc_i = 0; ibus_stb_i = 0;
      step();
      #4 chk("nosplit_idle", 160'(grant_o), 160'(2'b00));
      step();
      #4 chk("nosplit_d", 160'({grant_o, wbm_adr_o, dbus_ack_o}), 160'({2'b10, DA, 1'b1}));
      step();

      // Watchdog on dbus, then a slave ack racing the timeout
      do_reset();
      dbus_cyc_i = 1; dbus_stb_i = 1; dbus_adr_i = DA;
      step();
      for (int k = 1; k <= 12; k++) begin
         wbm_ack_i = (k == 12);
         #4;
         chk($sformatf("wdog_k%0d", k), 160'({dbus_err_o, dbus_ack_o, ibus_err_o}),
             160'({(k == 4 || k == 8), (k == 12), 1'b0}));
         step();
      end

      // Asynchronous reset mid-burst
      do_reset();
      ibus_cyc_i = 1; ibus_stb_i = 1; ibus_adr_i = IA; wbm_ack_i = 1;
      step();
      for (int b = 0; b < 4; b++) step();
      #2 rst = 1'b0;
      #1 chk("rst_async", 160'({wbm_cyc_o, grant_o, ibus_ack_o}), 160'(0));
      dbus_cyc_i = 1; dbus_stb_i = 1;
      step();
      rst = 1'b1;
      #4 chk("rst_after_idle", 160'(grant_o), 160'(2'b00));
      step();
      #4 chk("rst_after_d", 160'(grant_o), 160'(2'b10));
      step();

      // Randomized run against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 9) == 0) ibus_cyc_i = ~ibus_cyc_i;
         if ($urandom_range(0, 9) == 0) dbus_cyc_i = ~dbus_cyc_i;
         ibus_stb_i = ($urandom_range(0, 4) != 0);
         dbus_stb_i = ($urandom_range(0, 4) != 0);
         ibus_adr_i = $urandom; ibus_dat_i = $urandom; ibus_we_i = 1'($urandom);
         ibus_sel_i = 4'($urandom); ibus_cti_i = 3'($urandom); ibus_bte_i = 2'($urandom);
         dbus_adr_i = $urandom; dbus_dat_i = $urandom; dbus_we_i = 1'($urandom);
         dbus_sel_i = 4'($urandom); dbus_cti_i = 3'($urandom); dbus_bte_i = 2'($urandom);
         wbm_dat_i = $urandom;
         begin
            int r;
            r = int'($urandom_range(0, 99));
            wbm_ack_i = (r < 20);
            wbm_err_i = (r >= 20 && r < 24);
            wbm_rty_i = (r >= 24 && r < 27);
         end
         #4;
         chk("rand", dut_vec(), model_vec());
         model_step();
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
